// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (counts, syncs, blanking).
// Define VGA_TIMING_FRAME_PULSE_EN to add the one-cycle frame_start output.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out
`ifdef VGA_TIMING_FRAME_PULSE_EN
  ,
  output logic        frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // 12-bit bounds so a window ending at 2048 still compares correctly
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE  = 12'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
    $error("vga_timing_gen: totals exceed 2048");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        h_wrap;
  logic        v_wrap;
  logic [11:0] hext;
  logic [11:0] vext;

  // Flags decode the next counts so they register in step with them
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
    end
    hext    = {1'b0, hcount_d};
    vext    = {1'b0, vcount_d};
    hblnk_d = (hext >= H_ACT);
    vblnk_d = (vext >= V_ACT);
    hsync_d = ((hext >= H_SS) && (hext < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((vext >= V_SS) && (vext < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;

`ifdef VGA_TIMING_FRAME_PULSE_EN
  logic frame_q, frame_d;

  // Only a true frame wrap pulses; the post-reset (0,0) does not
  always_comb begin
    frame_d = h_wrap & v_wrap;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame_start = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing plus a small-raster instance.
// Model derives raster position from edges counted since reset release.
module tb_vga_timing_gen;

  localparam int DHA = 1024, DHF = 24, DHS = 136, DHB = 160;
  localparam int DVA = 768,  DVF = 3,  DVS = 6,   DVB = 29;
  localparam int DHT = DHA + DHF + DHS + DHB;
  localparam int DVT = DVA + DVF + DVS + DVB;

  localparam int SHA = 40, SHF = 6, SHS = 10, SHB = 8;
  localparam int SVA = 30, SVF = 2, SVS = 3,  SVB = 4;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } pos_t;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  logic [10:0] hc_d, vc_d, hc_s, vc_s;
  logic hs_d, vs_d, hb_d, vb_d;
  logic hs_s, vs_s, hb_s, vb_s;
`ifdef VGA_TIMING_FRAME_PULSE_EN
  logic fs_d, fs_s;
`endif

  vga_timing_gen dut_d (
    .pclk(pclk), .rst(rst),
    .hcount_out(hc_d), .vcount_out(vc_d),
    .hsync_out(hs_d), .vsync_out(vs_d),
    .hblnk_out(hb_d), .vblnk_out(vb_d)
`ifdef VGA_TIMING_FRAME_PULSE_EN
    , .frame_start(fs_d)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_s (
    .pclk(pclk), .rst(rst),
    .hcount_out(hc_s), .vcount_out(vc_s),
    .hsync_out(hs_s), .vsync_out(vs_s),
    .hblnk_out(hb_s), .vblnk_out(vb_s)
`ifdef VGA_TIMING_FRAME_PULSE_EN
    , .frame_start(fs_s)
`endif
  );

  pos_t obs_d, obs_s;
  assign obs_d = {hc_d, vc_d, hs_d, vs_d, hb_d, vb_d};
  assign obs_s = {hc_s, vc_s, hs_s, vs_s, hb_s, vb_s};

  int n;
  always @(posedge pclk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  int checks   = 0;
  int failures = 0;

  function automatic pos_t model(int k, int ha, int hf, int hsw, int hbp,
                                 int va, int vf, int vsw, int vbp,
                                 bit hpol, bit vpol);
    pos_t e;
    int ht, vt, p, h, v;
    ht = ha + hf + hsw + hbp;
    vt = va + vf + vsw + vbp;
    p  = k % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hb = (h >= ha);
    e.vb = (v >= va);
    e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hpol : ~hpol;
    e.vs = (v >= va + vf && v < va + vf + vsw) ? vpol : ~vpol;
    return e;
  endfunction

  function automatic pos_t exp_d(int k);
    return model(k, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b0, 1'b0);
  endfunction

  function automatic pos_t exp_s(int k);
    return model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b0);
  endfunction

  // Reset state: counts and blanks zero, syncs at their inactive level
  localparam pos_t RST_D = '{h: 11'd0, v: 11'd0, hs: 1'b1, vs: 1'b1,
                             hb: 1'b0, vb: 1'b0};
  localparam pos_t RST_S = '{h: 11'd0, v: 11'd0, hs: 1'b0, vs: 1'b1,
                             hb: 1'b0, vb: 1'b0};

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      checks++;
      if (obs_d !== RST_D) begin
        failures++;
        $display("FAIL reset_dflt got %h exp %h", obs_d, RST_D);
      end
      checks++;
      if (obs_s !== RST_S) begin
        failures++;
        $display("FAIL reset_small got %h exp %h", obs_s, RST_S);
      end
`ifdef VGA_TIMING_FRAME_PULSE_EN
      checks++;
      if ({fs_d, fs_s} !== 2'b00) begin
        failures++;
        $display("FAIL reset_fs got %b%b exp 00", fs_d, fs_s);
      end
`endif
    end
    rst = 1'b1;
    @(negedge pclk);
    checks++;
    if (hc_d !== 11'd1 || vc_d !== 11'd0) begin
      failures++;
      $display("FAIL release_first got h=%0d v=%0d exp h=1 v=0", hc_d, vc_d);
    end
    checks++;
    if (hc_s !== 11'd1) begin
      failures++;
      $display("FAIL release_small got h=%0d exp 1", hc_s);
    end
`ifdef VGA_TIMING_FRAME_PULSE_EN
    checks++;
    if ({fs_d, fs_s} !== 2'b00) begin
      failures++;
      $display("FAIL release_fs got %b%b exp 00", fs_d, fs_s);
    end
`endif
  endtask

  task automatic test_line_wrap;
    int hs_low;
    logic [10:0] prev_h;
    hs_low = 0;
    prev_h = hc_d;
    while (n < DHT + 20) begin
      @(negedge pclk);
      checks++;
      if (obs_d !== exp_d(n)) begin
        failures++;
        $display("FAIL line_model n=%0d got %h exp %h", n, obs_d, exp_d(n));
      end
      if (vc_d == 11'd0 && hs_d == 1'b0) hs_low++;
      if (hc_d == 11'd1047 || hc_d == 11'd1184) begin
        checks++;
        if (hs_d !== 1'b1) begin
          failures++;
          $display("FAIL hsync_edge h=%0d got %b exp 1", hc_d, hs_d);
        end
      end
      if (hc_d == 11'd1048 || hc_d == 11'd1183) begin
        checks++;
        if (hs_d !== 1'b0) begin
          failures++;
          $display("FAIL hsync_edge h=%0d got %b exp 0", hc_d, hs_d);
        end
      end
      if (hc_d == 11'd1023 || hc_d == 11'd1024) begin
        checks++;
        if (hb_d !== (hc_d == 11'd1024)) begin
          failures++;
          $display("FAIL hblnk_edge h=%0d got %b", hc_d, hb_d);
        end
      end
      if (prev_h == 11'd1343) begin
        checks++;
        if (hc_d !== 11'd0 || vc_d !== 11'd1 || hb_d !== 1'b0) begin
          failures++;
          $display("FAIL line_wrap got h=%0d v=%0d hb=%b exp 0 1 0",
                   hc_d, vc_d, hb_d);
        end
      end
      prev_h = hc_d;
    end
    checks++;
    if (hs_low != 136) begin
      failures++;
      $display("FAIL hsync_width got %0d exp 136", hs_low);
    end
  endtask

  task automatic test_frames;
    int stop, vs_cnt, vb_cnt, fs_cnt;
    stop   = 2 * SFR + 10 + int'($urandom_range(0, 200));
    vs_cnt = 0;
    vb_cnt = 0;
    fs_cnt = 0;
    while (n < stop) begin
      @(negedge pclk);
      checks++;
      if (obs_s !== exp_s(n)) begin
        failures++;
        $display("FAIL frame_model n=%0d got %h exp %h", n, obs_s, exp_s(n));
      end
      checks++;
      if (obs_d !== exp_d(n)) begin
        failures++;
        $display("FAIL dflt_model n=%0d got %h exp %h", n, obs_d, exp_d(n));
      end
      if (n < 2 * SFR) begin
        if (vs_s == 1'b0) vs_cnt++;
        if (vb_s == 1'b1) vb_cnt++;
      end
`ifdef VGA_TIMING_FRAME_PULSE_EN
      checks++;
      if (fs_s !== (n % SFR == 0)) begin
        failures++;
        $display("FAIL frame_start n=%0d got %b", n, fs_s);
      end
      if (fs_s === 1'b1) fs_cnt++;
      checks++;
      if (fs_d !== 1'b0) begin
        failures++;
        $display("FAIL frame_start_dflt n=%0d got %b exp 0", n, fs_d);
      end
`endif
    end
    checks++;
    if (vs_cnt != 2 * SVS * SHT) begin
      failures++;
      $display("FAIL vsync_cycles got %0d exp %0d", vs_cnt, 2 * SVS * SHT);
    end
    checks++;
    if (vb_cnt != 2 * (SVT - SVA) * SHT) begin
      failures++;
      $display("FAIL vblnk_cycles got %0d exp %0d", vb_cnt,
               2 * (SVT - SVA) * SHT);
    end
`ifdef VGA_TIMING_FRAME_PULSE_EN
    checks++;
    if (fs_cnt != 2) begin
      failures++;
      $display("FAIL frame_start_count got %0d exp 2", fs_cnt);
    end
`else
    if (fs_cnt != 0) failures++;
`endif
  endtask

  task automatic test_async_reset;
    for (int it = 0; it < 3; it++) begin
      repeat (int'($urandom_range(10, 3000))) @(posedge pclk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (obs_d !== RST_D || obs_s !== RST_S) begin
        failures++;
        $display("FAIL async_reset got %h %h exp %h %h",
                 obs_d, obs_s, RST_D, RST_S);
      end
`ifdef VGA_TIMING_FRAME_PULSE_EN
      checks++;
      if ({fs_d, fs_s} !== 2'b00) begin
        failures++;
        $display("FAIL async_reset_fs got %b%b exp 00", fs_d, fs_s);
      end
`endif
      repeat (int'($urandom_range(1, 4))) @(negedge pclk);
      checks++;
      if (obs_s !== RST_S) begin
        failures++;
        $display("FAIL reset_hold got %h exp %h", obs_s, RST_S);
      end
      rst = 1'b1;
      @(negedge pclk);
      checks++;
      if (hc_s !== 11'd1 || vc_s !== 11'd0 || hc_d !== 11'd1) begin
        failures++;
        $display("FAIL restart got hs=%0d vs=%0d hd=%0d exp 1 0 1",
                 hc_s, vc_s, hc_d);
      end
      repeat (150) begin
        @(negedge pclk);
        checks++;
        if (obs_s !== exp_s(n) || obs_d !== exp_d(n)) begin
          failures++;
          $display("FAIL restart_model n=%0d got %h %h exp %h %h",
                   n, obs_s, obs_d, exp_s(n), exp_d(n));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_frames();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
